sample_stream_fifo: RTL and testbench

//  Parametrised ready/valid stream buffer, successor to the fixed 8-bit passthrough sample block.

---
 rtl/sample_stream_fifo.sv | 118 +++++++++++
 tb/tb_sample_stream_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_stream_fifo.sv
// sample_stream_fifo
// Ready/valid first-word-fall-through stream buffer with occupancy and
// wrapping accept/emit counters. stream_in_ready is registered so the
// consumer's ready never reaches the producer combinationally.
module sample_stream_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 4,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    stream_in_valid,
    output logic                    stream_in_ready,
    input  logic [DATA_WIDTH-1:0]   stream_in_data,
    output logic                    stream_out_valid,
    input  logic                    stream_out_ready,
    output logic [DATA_WIDTH-1:0]   stream_out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic [COUNT_WIDTH-1:0]  in_count,
    output logic [COUNT_WIDTH-1:0]  out_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(DEPTH);

    // Storage array; no reset needed because level gates every read.
    logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

    logic [PTR_W-1:0]       rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0]       wr_ptr_q,    wr_ptr_d;
    logic [LVL_W-1:0]       level_q,     level_d;
    logic                   ready_q,     ready_d;
    logic [COUNT_WIDTH-1:0] in_count_q,  in_count_d;
    logic [COUNT_WIDTH-1:0] out_count_q, out_count_d;
    logic [DATA_WIDTH-1:0]  hold_q,      hold_d;

    logic                   push;
    logic                   pop;
    logic                   out_valid;
    logic [DATA_WIDTH-1:0]  head_data;

    // Handshake decode; a flush cycle suppresses both transfers.
    always_comb begin
        out_valid = (level_q != '0);
        head_data = mem_q[rd_ptr_q];
        push      = stream_in_valid & ready_q & ~flush;
        pop       = out_valid & stream_out_ready & ~flush;
    end

    // Next-state for pointers, occupancy, ready, counters and held output word.
    always_comb begin
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        level_d     = level_q;
        in_count_d  = in_count_q + COUNT_WIDTH'(push);
        out_count_d = out_count_q + COUNT_WIDTH'(pop);
        // Remember the current head so the output holds its last value once empty.
        hold_d      = out_valid ? head_data : hold_q;

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);
        end

        // Looking at next-cycle occupancy keeps ready registered yet exact.
        ready_d = (level_d < FULL_LEVEL) & ~flush;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            level_q     <= '0;
            ready_q     <= 1'b0;
            in_count_q  <= '0;
            out_count_q <= '0;
            hold_q      <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            level_q     <= level_d;
            ready_q     <= ready_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            hold_q      <= hold_d;
        end
    end

    // Word write on an accepted input transfer.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= stream_in_data;
        end
    end

    // Output drive: head word while valid, otherwise the last head seen.
    always_comb begin
        stream_in_ready  = ready_q;
        stream_out_valid = out_valid;
        stream_out_data  = out_valid ? head_data : hold_q;
        level            = level_q;
        in_count         = in_count_q;
        out_count        = out_count_q;
    end

endmodule

// File: tb/tb_sample_stream_fifo.sv
// Bench for sample_stream_fifo: queue scoreboard model sampled on the falling
// edge, directed phases followed by a random phase with an async reset.
module tb_sample_stream_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          reset_n   = 1'b1;
    logic          flush     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data   = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;
    logic [CW-1:0] in_count;
    logic [CW-1:0] out_count;

    int checks = 0;
    int errors = 0;
    bit verbose = 1'b1;

    // Reference model state (values expected after the next rising edge).
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] last_data = '0;
    logic [CW-1:0] exp_in    = '0;
    logic [CW-1:0] exp_out   = '0;
    logic          exp_ready = 1'b0;
    bit            do_push;
    bit            do_pop;

    sample_stream_fifo #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .flush            (flush),
        .stream_in_valid  (in_valid),
        .stream_in_ready  (in_ready),
        .stream_in_data   (in_data),
        .stream_out_valid (out_valid),
        .stream_out_ready (out_ready),
        .stream_out_data  (out_data),
        .level            (level),
        .in_count         (in_count),
        .out_count        (out_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard and per-cycle output checks.
    always @(negedge clk) begin
        if (!reset_n) begin
            check_eq("rst_in_ready", in_ready, 1'b0);
            check_eq("rst_out_valid", out_valid, 1'b0);
            check_eq("rst_out_data", out_data, '0);
            check_eq("rst_level", level, '0);
            check_eq("rst_in_count", in_count, '0);
            check_eq("rst_out_count", out_count, '0);
            exp_q.delete();
            exp_in    = '0;
            exp_out   = '0;
            last_data = '0;
            exp_ready = 1'b1;   // release always happens before the next rising edge
        end else begin
            check_eq("out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0)
                check_eq("out_data", out_data, exp_q[0]);
            else
                check_eq("out_data_hold", out_data, last_data);
            check_eq("level", level, exp_q.size());
            check_eq("in_count", in_count, exp_in);
            check_eq("out_count", out_count, exp_out);
            check_eq("in_ready", in_ready, exp_ready);

            do_push = in_valid && exp_ready && !flush;
            do_pop  = (exp_q.size() != 0) && out_ready && !flush;
            if (exp_q.size() != 0) last_data = exp_q[0];
            if (do_pop) begin
                if (verbose) $display("POP  %02h level=%0d", exp_q[0], exp_q.size());
                void'(exp_q.pop_front());
                exp_out++;
            end
            if (do_push) begin
                if (verbose) $display("PUSH %02h level=%0d", in_data, exp_q.size());
                exp_q.push_back(in_data);
                exp_in++;
            end
            if (flush) begin
                if (verbose) $display("FLUSH level=%0d", exp_q.size());
                exp_q.delete();
            end
            exp_ready = (exp_q.size() < DEPTH) && !flush;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) check_eq("send_timeout", 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        #1;
        check_eq("rst_now_ready", in_ready, 1'b0);
        check_eq("rst_now_valid", out_valid, 1'b0);
        check_eq("rst_now_data", out_data, '0);
        check_eq("rst_now_level", level, '0);
        check_eq("rst_now_counts", {in_count, out_count}, '0);
        @(negedge clk);
        @(negedge clk);
        #2;
        reset_n = 1'b1;
        tick();
        check_eq("rst_release_ready", in_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        int rst_at;

        // Reset and release.
        do_reset();
        check_eq("t1_level", level, '0);

        // Fill to full with the consumer stalled, then drain in order.
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        check_eq("t2_full_level", level, 4);
        check_eq("t2_full_ready", in_ready, 1'b0);
        out_ready = 1'b1;
        repeat (4) tick();
        out_ready = 1'b0;
        check_eq("t2_empty_level", level, 0);
        check_eq("t2_in_count", in_count, 4);
        check_eq("t2_out_count", out_count, 4);

        // Continuous streaming: one word per cycle, level pinned at 1.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = DW'($urandom);
            tick();
            check_eq("t3_level", level, 1);
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        tick();

        // Flush at level 3 with valid held high.
        send(8'hA1);
        send(8'hA2);
        send(8'hA3);
        check_eq("t4_level3", level, 3);
        in_valid = 1'b1;
        in_data  = 8'hEE;
        flush    = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check_eq("t4_flush_level", level, 0);
        check_eq("t4_flush_valid", out_valid, 1'b0);
        check_eq("t4_flush_ready", in_ready, 1'b0);
        check_eq("t4_flush_in_count", in_count, exp_in);
        tick();
        check_eq("t4_ready_back", in_ready, 1'b1);

        // Counter wrap: 17 transfers with 4-bit counters.
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_data = DW'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        check_eq("t5_in_wrap", in_count, 1);
        check_eq("t5_out_wrap", out_count, 1);

        // Random traffic with an asynchronous reset at a random cycle.
        verbose = 1'b0;
        rst_at  = $urandom_range(500, 2500);
        for (int c = 0; c < 4000; c++) begin
            if (c == rst_at) do_reset();
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = DW'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            tick();
            if (level > LW'(DEPTH)) check_eq("t6_level_bound", level, DEPTH);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (DEPTH + 2) tick();
        check_eq("t6_drained", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
